// File: rtl/expr_pkg.sv
// Shared types and constants for the streaming expression recognizer.
package expr_pkg;

    typedef enum logic [2:0] {
        S_START,
        S_OP,
        S_NUM,
        S_CLOSE,
        S_ERR
    } state_e;

    typedef enum logic [2:0] {
        DIG,
        OP,
        LP,
        RP,
        SEP,
        SP,
        BAD
    } char_class_e;

    typedef logic [2:0] err_code_t;

    localparam err_code_t ERR_NONE      = 3'd0;
    localparam err_code_t ERR_SYNTAX    = 3'd1;
    localparam err_code_t ERR_DEPTH     = 3'd2;
    localparam err_code_t ERR_UNMATCHED = 3'd3;
    localparam err_code_t ERR_LONG      = 3'd4;
    localparam err_code_t ERR_UNCLOSED  = 3'd5;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_SLASH = 8'h2F;
    localparam logic [7:0] CH_LP    = 8'h28;
    localparam logic [7:0] CH_RP    = 8'h29;
    localparam logic [7:0] CH_SEMI  = 8'h3B;
    localparam logic [7:0] CH_SPACE = 8'h20;

endpackage

// File: rtl/expr_paren_fsm_if.sv
// Character-stream input and status outputs of the expression recognizer.
interface expr_paren_fsm_if #(
    parameter int unsigned DEPTH_W = 3,
    parameter int unsigned CNT_W   = 8
);
    import expr_pkg::*;

    logic               in_valid;
    logic [7:0]         in;
    logic               out;
    logic [DEPTH_W-1:0] depth;
    logic [CNT_W-1:0]   expr_cnt;
    logic               err;
    err_code_t          err_code;

    modport master (
        output in_valid, in,
        input  out, depth, expr_cnt, err, err_code
    );

    modport slave (
        input  in_valid, in,
        output out, depth, expr_cnt, err, err_code
    );
endinterface

// File: rtl/expr_char_class.sv
// Combinational ASCII classifier; the operator set is fixed at elaboration.
module expr_char_class
    import expr_pkg::*;
#(
    parameter bit ALLOW_SUB = 1'b1,
    parameter bit ALLOW_DIV = 1'b0
) (
    input  logic [7:0]  in,
    output char_class_e cls
);

    always_comb begin
        cls = BAD;
        if (in >= CH_0 && in <= CH_9) begin
            cls = DIG;
        end else begin
            case (in)
                CH_PLUS, CH_STAR: cls = OP;
                CH_MINUS:         if (ALLOW_SUB) cls = OP;
                CH_SLASH:         if (ALLOW_DIV) cls = OP;
                CH_LP:            cls = LP;
                CH_RP:            cls = RP;
                CH_SEMI:          cls = SEP;
                CH_SPACE:         cls = SP;
                default:          cls = BAD;
            endcase
        end
    end

endmodule

// File: rtl/expr_paren_fsm.sv
// Recognizer for ';'-terminated expressions with bounded operands and nesting.
module expr_paren_fsm
    import expr_pkg::*;
#(
    parameter int unsigned MAX_DEPTH  = 7,
    parameter int unsigned DEPTH_W    = $clog2(MAX_DEPTH + 1),
    parameter int unsigned MAX_DIGITS = 4,
    parameter bit          ALLOW_SUB  = 1'b1,
    parameter bit          ALLOW_DIV  = 1'b0,
    parameter int unsigned CNT_W      = 8
) (
    input logic             clk,
    input logic             clr,
    expr_paren_fsm_if.slave bus
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
    localparam logic [3:0]         DIG_MAX   = 4'(MAX_DIGITS);

    char_class_e        cls;
    state_e             state;
    logic [DEPTH_W-1:0] depth;
    logic [3:0]         digit_cnt;
    logic [CNT_W-1:0]   expr_cnt;
    logic               err;
    err_code_t          err_code;
    logic               out;

    expr_char_class #(
        .ALLOW_SUB (ALLOW_SUB),
        .ALLOW_DIV (ALLOW_DIV)
    ) u_class (
        .in  (bus.in),
        .cls (cls)
    );

    // out is registered alongside each transition so it equals
    // (state in {S_NUM, S_CLOSE}) && depth == 0 for the new state.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= S_START;
            depth     <= '0;
            digit_cnt <= '0;
            expr_cnt  <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            out       <= 1'b0;
        end else if (bus.in_valid && cls != SP) begin
            case (state)
                S_START, S_OP: begin
                    if (cls == DIG) begin
                        state     <= S_NUM;
                        digit_cnt <= 4'd1;
                        out       <= (depth == '0);
                    end else if (cls == LP && depth != DEPTH_MAX) begin
                        depth <= depth + 1'b1;
                    end else begin
                        state    <= S_ERR;
                        err      <= 1'b1;
                        err_code <= (cls == LP) ? ERR_DEPTH : ERR_SYNTAX;
                        out      <= 1'b0;
                    end
                end
                S_NUM, S_CLOSE: begin
                    case (cls)
                        DIG: begin
                            if (state == S_CLOSE || digit_cnt == DIG_MAX) begin
                                state    <= S_ERR;
                                err      <= 1'b1;
                                err_code <= (state == S_CLOSE) ? ERR_SYNTAX : ERR_LONG;
                                out      <= 1'b0;
                            end else begin
                                digit_cnt <= digit_cnt + 1'b1;
                            end
                        end
                        OP: begin
                            state <= S_OP;
                            out   <= 1'b0;
                        end
                        RP: begin
                            if (depth == '0) begin
                                state    <= S_ERR;
                                err      <= 1'b1;
                                err_code <= ERR_UNMATCHED;
                                out      <= 1'b0;
                            end else begin
                                state <= S_CLOSE;
                                depth <= depth - 1'b1;
                                out   <= (depth == DEPTH_ONE);
                            end
                        end
                        SEP: begin
                            if (depth != '0) begin
                                state    <= S_ERR;
                                err      <= 1'b1;
                                err_code <= ERR_UNCLOSED;
                            end else begin
                                state     <= S_START;
                                expr_cnt  <= expr_cnt + 1'b1;
                                digit_cnt <= '0;
                            end
                            out <= 1'b0;
                        end
                        default: begin
                            state    <= S_ERR;
                            err      <= 1'b1;
                            err_code <= ERR_SYNTAX;
                            out      <= 1'b0;
                        end
                    endcase
                end
                S_ERR: begin
                end
                default: begin
                    state    <= S_ERR;
                    err      <= 1'b1;
                    err_code <= ERR_SYNTAX;
                    out      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out      = out;
    assign bus.depth    = depth;
    assign bus.expr_cnt = expr_cnt;
    assign bus.err      = err;
    assign bus.err_code = err_code;

endmodule

// File: tb/tb_expr_paren_fsm.sv
// Drives two differently configured recognizers with one stream and checks both.
module tb_expr_paren_fsm;

    typedef struct {
        int maxd;
        int maxdig;
        bit sub;
        bit div;
        int cntw;
    } p_t;

    typedef struct {
        int depth;
        int digits;
        int cnt;
        int code;
        bit need;
        bit closed;
    } m_t;

    typedef struct {
        string s;
        int    a_out, a_depth, a_code, a_cnt;
        int    b_out, b_depth, b_code, b_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   total = 0;
    int   bad = 0;

    p_t pa = '{maxd: 7, maxdig: 4, sub: 1'b1, div: 1'b0, cntw: 8};
    p_t pb = '{maxd: 2, maxdig: 4, sub: 1'b0, div: 1'b1, cntw: 2};
    m_t ma;
    m_t mb;
    vec_t vecs[$];

    always #5 clk = ~clk;

    expr_paren_fsm_if #(.DEPTH_W(3), .CNT_W(8)) ia ();
    expr_paren_fsm_if #(.DEPTH_W(2), .CNT_W(2)) ib ();

    expr_paren_fsm #(
        .MAX_DEPTH(7), .DEPTH_W(3), .MAX_DIGITS(4),
        .ALLOW_SUB(1'b1), .ALLOW_DIV(1'b0), .CNT_W(8)
    ) dut_a (.clk(clk), .clr(clr), .bus(ia));

    expr_paren_fsm #(
        .MAX_DEPTH(2), .DEPTH_W(2), .MAX_DIGITS(4),
        .ALLOW_SUB(1'b0), .ALLOW_DIV(1'b1), .CNT_W(2)
    ) dut_b (.clk(clk), .clr(clr), .bus(ib));

    function automatic m_t mreset();
        m_t m;
        m.depth = 0; m.digits = 0; m.cnt = 0; m.code = 0; m.need = 1'b1; m.closed = 1'b0;
        return m;
    endfunction

    // Token-level model: "need" means an operand is expected next.
    function automatic m_t mstep(m_t m, p_t p, logic [7:0] c);
        bit isdig;
        bit isop;
        if (m.code != 0 || c == " ") return m;
        isdig = (c >= "0" && c <= "9");
        isop  = (c == "+" || c == "*" || (p.sub && c == "-") || (p.div && c == "/"));
        if (m.need) begin
            if (isdig) begin
                m.need = 1'b0; m.closed = 1'b0; m.digits = 1;
            end else if (c == "(") begin
                if (m.depth == p.maxd) m.code = 2;
                else m.depth++;
            end else begin
                m.code = 1;
            end
        end else if (isdig) begin
            if (m.closed) m.code = 1;
            else if (m.digits == p.maxdig) m.code = 4;
            else m.digits++;
        end else if (isop) begin
            m.need = 1'b1; m.closed = 1'b0; m.digits = 0;
        end else if (c == ")") begin
            if (m.depth == 0) m.code = 3;
            else begin
                m.depth--; m.closed = 1'b1; m.digits = 0;
            end
        end else if (c == ";") begin
            if (m.depth != 0) m.code = 5;
            else begin
                m.need = 1'b1; m.closed = 1'b0; m.digits = 0;
                m.cnt = (m.cnt + 1) % (1 << p.cntw);
            end
        end else begin
            m.code = 1;
        end
        return m;
    endfunction

    function automatic int mout(m_t m);
        return (m.code == 0 && !m.need && m.depth == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit v, input logic [7:0] c);
        clr = r;
        ia.in_valid = v; ia.in = c;
        ib.in_valid = v; ib.in = c;
        @(posedge clk);
        #1;
        if (r) begin
            ma = mreset(); mb = mreset();
        end else if (v) begin
            ma = mstep(ma, pa, c); mb = mstep(mb, pb, c);
        end
        clr = 1'b0;
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) cyc(1'b0, 1'b1, s[i]);
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, " A.out"}, int'(ia.out), mout(ma));
        chk({tag, " A.depth"}, int'(ia.depth), ma.depth);
        chk({tag, " A.cnt"}, int'(ia.expr_cnt), ma.cnt);
        chk({tag, " A.err"}, int'(ia.err), (ma.code != 0) ? 1 : 0);
        chk({tag, " A.code"}, int'(ia.err_code), ma.code);
        chk({tag, " B.out"}, int'(ib.out), mout(mb));
        chk({tag, " B.depth"}, int'(ib.depth), mb.depth);
        chk({tag, " B.cnt"}, int'(ib.expr_cnt), mb.cnt);
        chk({tag, " B.err"}, int'(ib.err), (mb.code != 0) ? 1 : 0);
        chk({tag, " B.code"}, int'(ib.err_code), mb.code);
    endtask

    initial begin
        ma = mreset();
        mb = mreset();
        ia.in_valid = 1'b0; ia.in = 8'h00;
        ib.in_valid = 1'b0; ib.in = 8'h00;

        //               string           A: out dep code cnt   B: out dep code cnt
        vecs.push_back('{"1;2*3;45;",        0, 0, 0, 3,          0, 0, 0, 3});
        vecs.push_back('{"(((",              0, 3, 0, 0,          0, 2, 2, 0});
        vecs.push_back('{"(((1)",            0, 2, 0, 0,          0, 2, 2, 0});
        vecs.push_back('{"12345",            0, 0, 4, 0,          0, 0, 4, 0});
        vecs.push_back('{"5)",               0, 0, 3, 0,          0, 0, 3, 0});
        vecs.push_back('{"(5;",              0, 1, 5, 0,          0, 1, 5, 0});
        vecs.push_back('{"5-2",              1, 0, 0, 0,          0, 0, 1, 0});
        vecs.push_back('{"5 - 2",            1, 0, 0, 0,          0, 0, 1, 0});
        vecs.push_back('{"8/2",              0, 0, 1, 0,          1, 0, 0, 0});
        vecs.push_back('{"1;1;1;1;1;1;1;",   0, 0, 0, 7,          0, 0, 0, 3});
        vecs.push_back('{";",                0, 0, 1, 0,          0, 0, 1, 0});
        vecs.push_back('{"007",              1, 0, 0, 0,          1, 0, 0, 0});
        vecs.push_back('{"(1+2)*3",          1, 0, 0, 0,          1, 0, 0, 0});
        vecs.push_back('{"1(",               0, 0, 1, 0,          0, 0, 1, 0});
        vecs.push_back('{"(1)2",             0, 0, 1, 0,          0, 0, 1, 0});
        vecs.push_back('{"1+;",              0, 0, 1, 0,          0, 0, 1, 0});
        vecs.push_back('{"1;;",              0, 0, 1, 1,          0, 0, 1, 1});
        vecs.push_back('{"((((((((",         0, 7, 2, 0,          0, 2, 2, 0});
        vecs.push_back('{"1#",               0, 0, 1, 0,          0, 0, 1, 0});
        vecs.push_back('{"1 2",              1, 0, 0, 0,          1, 0, 0, 0});

        cyc(1'b1, 1'b1, "(");
        cyc(1'b1, 1'b0, 8'h00);
        chk("reset A.out", int'(ia.out), 0);
        chk("reset A.depth", int'(ia.depth), 0);
        chk("reset A.cnt", int'(ia.expr_cnt), 0);
        chk("reset A.err", int'(ia.err), 0);
        chk("reset A.code", int'(ia.err_code), 0);

        foreach (vecs[k]) begin
            cyc(1'b1, 1'b0, 8'h00);
            send(vecs[k].s);
            chk({"vec '", vecs[k].s, "' A.out"}, int'(ia.out), vecs[k].a_out);
            chk({"vec '", vecs[k].s, "' A.depth"}, int'(ia.depth), vecs[k].a_depth);
            chk({"vec '", vecs[k].s, "' A.code"}, int'(ia.err_code), vecs[k].a_code);
            chk({"vec '", vecs[k].s, "' A.err"}, int'(ia.err), (vecs[k].a_code != 0) ? 1 : 0);
            chk({"vec '", vecs[k].s, "' A.cnt"}, int'(ia.expr_cnt), vecs[k].a_cnt);
            chk({"vec '", vecs[k].s, "' B.out"}, int'(ib.out), vecs[k].b_out);
            chk({"vec '", vecs[k].s, "' B.depth"}, int'(ib.depth), vecs[k].b_depth);
            chk({"vec '", vecs[k].s, "' B.code"}, int'(ib.err_code), vecs[k].b_code);
            chk({"vec '", vecs[k].s, "' B.err"}, int'(ib.err), (vecs[k].b_code != 0) ? 1 : 0);
            chk({"vec '", vecs[k].s, "' B.cnt"}, int'(ib.expr_cnt), vecs[k].b_cnt);
            cmp_model({"vec '", vecs[k].s, "' model"});
        end

        // Character-by-character walk through a nested expression.
        cyc(1'b1, 1'b0, 8'h00);
        send("12");
        chk("walk out after 2", int'(ia.out), 1);
        send("+");
        chk("walk out after +", int'(ia.out), 0);
        send("(");
        chk("walk depth after (", int'(ia.depth), 1);
        send("3*45");
        chk("walk out inside parens", int'(ia.out), 0);
        send(")");
        chk("walk out after )", int'(ia.out), 1);
        chk("walk depth after )", int'(ia.depth), 0);
        chk("walk err", int'(ia.err), 0);

        // in_valid low must hold S_OP; the next digit then completes the operand.
        cyc(1'b1, 1'b0, 8'h00);
        send("1+");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, "x");
        chk("hold out", int'(ia.out), 0);
        chk("hold err", int'(ia.err), 0);
        send("2");
        chk("hold resumes out", int'(ia.out), 1);
        chk("hold resumes err", int'(ia.err), 0);

        // clr mid-expression discards the open parenthesis.
        cyc(1'b1, 1'b0, 8'h00);
        send("(7*");
        chk("pre-clr depth", int'(ia.depth), 1);
        cyc(1'b1, 1'b1, "(");
        chk("clr depth", int'(ia.depth), 0);
        chk("clr out", int'(ia.out), 0);
        chk("clr err", int'(ia.err), 0);
        send("8");
        chk("after clr out", int'(ia.out), 1);
        cmp_model("after clr model");

        // Random stream against the token-level model.
        begin
            string pool;
            pool = "0123456789+-*/();;  x0123456789";
            cyc(1'b1, 1'b0, 8'h00);
            for (int n = 0; n < 3000; n++) begin
                bit r;
                bit v;
                logic [7:0] c;
                r = ($urandom_range(0, 39) == 0);
                v = ($urandom_range(0, 3) != 0);
                c = pool[$urandom_range(0, pool.len() - 1)];
                cyc(r, v, c);
                cmp_model($sformatf("rand %0d", n));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
